// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder for the bit-serial sequence detectors: accepts words
// over valid/ready and streams them out one bit per clock with no inter-word bubble.
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;

  // The shift register always emits from its top bit, so LSB-first words are
  // stored bit-reversed at load time.
  function automatic logic [WIDTH-1:0] order_word(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

  assign din_ready  = (state == IDLE) || ((state == SHIFT) && (cnt == '0));
  assign accept     = din_valid && din_ready;
  assign ser_valid  = (state == SHIFT);
  assign busy       = ser_valid;
  assign ser_out    = shreg[WIDTH-1];
  assign frame_done = ser_valid && (cnt == '0);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          shreg_nxt = order_word(din);
          cnt_nxt   = LAST;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
          cnt_nxt   = cnt - CNT_W'(1);
        end else if (accept) begin
          shreg_nxt = order_word(din);
          cnt_nxt   = LAST;
        end else begin
          // Clearing the register keeps ser_out low while idle.
          state_nxt = IDLE;
          shreg_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        shreg_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed testbench for serial_bit_source (MSB-first and LSB-first instances).
module tb_serial_bit_source;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, ser_out, ser_valid, busy, frame_done;
  logic       l_din_ready, l_ser_out, l_ser_valid, l_busy, l_frame_done;

  int checks;
  int errors;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .frame_done(frame_done)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(l_din_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .busy(l_busy), .frame_done(l_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 8'h00; din_valid = 1'b0;
    #2;
    checks++;
    if ({ser_out, ser_valid, busy, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {ser_out, ser_valid, busy, frame_done});
    end
    step(); step();
    #2 rst = 1'b0;
    step();
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", din_ready);
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'b11011000;
    din = w; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (ser_valid !== 1'b1 || busy !== 1'b1 || ser_out !== w[8-k]) begin
        errors++;
        $display("FAIL single_bit%0d: ser_out=%b ser_valid=%b busy=%b expected %b 1 1", k, ser_out, ser_valid, busy, w[8-k]);
      end
      checks++;
      if (frame_done !== (k == 8)) begin
        errors++;
        $display("FAIL single_done%0d: got %b expected %b", k, frame_done, (k == 8));
      end
      step();
    end
    checks++;
    if ({ser_valid, ser_out, busy, frame_done, din_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL single_idle: got %b expected 00001", {ser_valid, ser_out, busy, frame_done, din_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    s = 16'hD81B;
    din = 8'hD8; din_valid = 1'b1;
    step();
    din = 8'h1B;
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) din_valid = 1'b0;
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== s[16-k]) begin
        errors++;
        $display("FAIL b2b_bit%0d: ser_out=%b ser_valid=%b expected %b 1", k, ser_out, ser_valid, s[16-k]);
      end
      checks++;
      if (din_ready !== (k == 8 || k == 16) || frame_done !== (k == 8 || k == 16)) begin
        errors++;
        $display("FAIL b2b_ready%0d: din_ready=%b frame_done=%b expected %b", k, din_ready, frame_done, (k == 8 || k == 16));
      end
      step();
    end
    checks++;
    if (ser_valid !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: ser_valid=%b din_ready=%b expected 0 1", ser_valid, din_ready);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] e;
    e = 8'b11011000;
    din = 8'b00011011; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (l_ser_valid !== 1'b1 || l_ser_out !== e[8-k] || l_frame_done !== (k == 8)) begin
        errors++;
        $display("FAIL lsb_bit%0d: ser_out=%b ser_valid=%b frame_done=%b expected %b 1 %b", k, l_ser_out, l_ser_valid, l_frame_done, e[8-k], (k == 8));
      end
      step();
    end
    checks++;
    if (l_ser_valid !== 1'b0 || l_ser_out !== 1'b0) begin
      errors++;
      $display("FAIL lsb_end: ser_valid=%b ser_out=%b expected 0 0", l_ser_valid, l_ser_out);
    end
  endtask

  task automatic test_stall();
    logic [15:0] s;
    s = 16'hD8FF;
    din = 8'hD8; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin din = 8'hFF; din_valid = 1'b1; end
      if (k == 9) din_valid = 1'b0;
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== s[16-k]) begin
        errors++;
        $display("FAIL stall_bit%0d: ser_out=%b ser_valid=%b expected %b 1", k, ser_out, ser_valid, s[16-k]);
      end
      if (k >= 3 && k <= 8) begin
        checks++;
        if (din_ready !== (k == 8)) begin
          errors++;
          $display("FAIL stall_ready%0d: got %b expected %b", k, din_ready, (k == 8));
        end
      end
      step();
    end
    checks++;
    if (ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: ser_valid=%b expected 0", ser_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    w = 8'hD8;
    din = w; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ser_out, ser_valid, busy, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async: got %b expected 0000", {ser_out, ser_valid, busy, frame_done});
    end
    step();
    #2 rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if ({ser_out, ser_valid, frame_done, din_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL midrst_residue%0d: got %b expected 0001", k, {ser_out, ser_valid, frame_done, din_ready});
      end
    end
    din = w; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== w[8-k] || frame_done !== (k == 8)) begin
        errors++;
        $display("FAIL midrst_bit%0d: ser_out=%b ser_valid=%b frame_done=%b expected %b 1 %b", k, ser_out, ser_valid, frame_done, w[8-k], (k == 8));
      end
      step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_stall();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
